// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with frame debounce
// Optional auto-repeat strobes when built with KEYPAD_AUTOREPEAT_EN defined.
module keypad_scanner #(
    parameter int SCAN_CLK_COUNT = 10,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int REPEAT_FRAMES  = 8,
`endif
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_pressed
);
    localparam int SCAN_W = $clog2(SCAN_CLK_COUNT);
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W  = $clog2(REPEAT_FRAMES + 1);
`endif

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t            state, state_nx;
    logic [3:0]        rows_meta, rows_sync;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        col_idx;
    logic [3:0]        samp0, samp1, samp2;
    logic [3:0]        cand, cand_nx;
    logic [DEB_W-1:0]  cnt, cnt_nx, rel_cnt, rel_nx;
    logic [3:0]        code_nx;
    logic              valid_nx, pressed_nx;
    logic              tc, frame_end;
    logic [15:0]       frame;
    logic [1:0]        low_cnt;
    logic [3:0]        hit_code;
    logic              is_none, is_single, accept;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0]  rep_cnt, rep_nx;
`endif

    assign tc        = (scan_cnt == SCAN_W'(SCAN_CLK_COUNT - 1));
    assign frame_end = tc && (col_idx == 2'd3);
    assign o_cols    = ~(4'b0001 << col_idx);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            scan_cnt  <= '0;
            col_idx   <= '0;
            samp0     <= 4'hF;
            samp1     <= 4'hF;
            samp2     <= 4'hF;
        end else begin
            rows_meta <= i_rows;
            rows_sync <= rows_meta;
            if (tc) begin
                scan_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                case (col_idx)
                    2'd0:    samp0 <= rows_sync;
                    2'd1:    samp1 <= rows_sync;
                    2'd2:    samp2 <= rows_sync;
                    default: ;
                endcase
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    // Column 3 is classified from the live sample so the frame closes on its own terminal count.
    always_comb begin
        frame    = {rows_sync, samp2, samp1, samp0};
        low_cnt  = '0;
        hit_code = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!frame[c*4 + r]) begin
                    if (low_cnt != 2'd2) low_cnt = low_cnt + 2'd1;
                    hit_code = 4'(r*4 + c);
                end
            end
        end
        is_none   = (low_cnt == 2'd0);
        is_single = (low_cnt == 2'd1);
    end

    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        cnt_nx     = cnt;
        rel_nx     = rel_cnt;
        code_nx    = o_key_code;
        valid_nx   = 1'b0;
        pressed_nx = o_key_pressed;
        accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nx     = rep_cnt;
`endif
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_nx = hit_code;
                        cnt_nx  = DEB_W'(1);
                        if (DEBOUNCE_SCANS <= 1) accept   = 1'b1;
                        else                     state_nx = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && hit_code == cand) begin
                        cnt_nx = cnt + DEB_W'(1);
                        if (int'(cnt) + 1 >= DEBOUNCE_SCANS) accept = 1'b1;
                    end else if (is_single) begin
                        cand_nx = hit_code;
                        cnt_nx  = DEB_W'(1);
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_nx = '0;
                    if (is_single) begin
                        if (int'(rep_cnt) + 1 >= REPEAT_FRAMES) valid_nx = 1'b1;
                        else                                    rep_nx   = rep_cnt + REP_W'(1);
                    end
`endif
                    if (is_none) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_nx   = IDLE;
                            pressed_nx = 1'b0;
                            rel_nx     = '0;
                        end else begin
                            state_nx = RELEASE;
                            rel_nx   = DEB_W'(1);
                        end
                    end else begin
                        rel_nx = '0;
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        if (int'(rel_cnt) + 1 >= DEBOUNCE_SCANS) begin
                            state_nx   = IDLE;
                            pressed_nx = 1'b0;
                            rel_nx     = '0;
                        end else begin
                            rel_nx = rel_cnt + DEB_W'(1);
                        end
                    end else begin
                        state_nx = PRESSED;
                        rel_nx   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_nx   = '0;
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (accept) begin
                state_nx   = PRESSED;
                code_nx    = cand_nx;
                valid_nx   = 1'b1;
                pressed_nx = 1'b1;
                rel_nx     = '0;
                cnt_nx     = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_nx     = '0;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            cand          <= '0;
            cnt           <= '0;
            rel_cnt       <= '0;
            o_key_code    <= '0;
            o_key_valid   <= 1'b0;
            o_key_pressed <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            state         <= state_nx;
            cand          <= cand_nx;
            cnt           <= cnt_nx;
            rel_cnt       <= rel_nx;
            o_key_code    <= code_nx;
            o_key_valid   <= valid_nx;
            o_key_pressed <= pressed_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt       <= rep_nx;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a simple key-matrix model
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  rows, cols, code;
    logic        valid, pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;
    int last_strobe = 0;
    int cyc;
    logic [3:0] exp_q[$];

    keypad_scanner dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rows       (rows),
        .o_cols       (cols),
        .o_key_code   (code),
        .o_key_valid  (valid),
        .o_key_pressed(pressed)
    );

    always #5 clk = ~clk;

    // keys[r*4+c] closed pulls row r low while column c is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            rows[r] = ~|(keys[r*4 +: 4] & ~cols);
    end

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst && valid) begin
                strobes++;
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: code %0d with no strobe expected (cycle %0d)", code, cyc);
                end else begin
                    check("strobe_code", int'(code), int'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        step(1);
        while (cyc % 40 != p) step(1);
    endtask

    initial begin
        int s0, m;
        logic [3:0] ecol;
        rst  = 1'b0;
        keys = '0;
        fork
            monitor();
        join_none

        step(3);
        check("rst_cols",    int'(cols), 14);
        check("rst_code",    int'(code), 0);
        check("rst_valid",   int'(valid), 0);
        check("rst_pressed", int'(pressed), 0);
        rst = 1'b1;

        // column walk: 10 cycles per column
        for (int k = 0; k < 80; k++) begin
            step(1);
            ecol = 4'hF & ~(4'h1 << ((cyc / 10) % 4));
            check("cols_walk", int'(cols), int'(ecol));
        end
        s0 = strobes;
        step(1000);
        check("idle_no_strobe", strobes - s0, 0);

        // clean press of key 9 (row2, col1)
        s0 = strobes;
        m  = cyc;
        exp_q.push_back(4'd9);
        keys[9] = 1'b1;
        step(400);
        check("key9_strobes", strobes - s0, 1);
        check("key9_latency_le_163", int'(last_strobe - m <= 163), 1);
        check("key9_pressed", int'(pressed), 1);
        keys = '0;
        step(20);
        check("key9_held_after_release", int'(pressed), 1);
        step(200);
        check("key9_released", int'(pressed), 0);

        // bounce on key 3 (row0, col3) phased so the col3 samples see released, released, pressed
        wait_phase(27);
        m  = cyc;
        s0 = strobes;
        for (int i = 0; i < 14; i++) begin
            keys[3] = (i % 2 == 0);
            step(7);
        end
        check("bounce_no_strobe", strobes - s0, 0);
        exp_q.push_back(4'd3);
        keys[3] = 1'b1;
        step(120);
        check("key3_strobes", strobes - s0, 1);
        check("key3_strobe_cycle", last_strobe, m + 173);
        keys = '0;
        step(250);

        // two keys from idle never accept
        s0 = strobes;
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        step(300);
        check("multi_no_strobe", strobes - s0, 0);
        check("multi_not_pressed", int'(pressed), 0);
        keys = '0;
        step(100);

        // key 4 accepted, then key 6 added while held
        s0 = strobes;
        exp_q.push_back(4'd4);
        keys[4] = 1'b1;
        step(200);
        check("key4_strobes", strobes - s0, 1);
        keys[6] = 1'b1;
        step(300);
        check("key4_6_single_strobe", strobes - s0, 1);
        check("key4_6_pressed", int'(pressed), 1);
        keys = '0;
        step(250);
        check("key4_released", int'(pressed), 0);

        // reset during debounce of key 15 after two frames
        wait_phase(0);
        keys[15] = 1'b1;
        step(90);
        rst = 1'b0;
        #1;
        check("midrst_cols",    int'(cols), 14);
        check("midrst_code",    int'(code), 0);
        check("midrst_valid",   int'(valid), 0);
        check("midrst_pressed", int'(pressed), 0);
        step(3);
        s0 = strobes;
        exp_q.push_back(4'd15);
        rst = 1'b1;
        step(130);
        check("key15_strobes", strobes - s0, 1);
        check("key15_strobe_cycle", last_strobe, 120);
        keys = '0;
        step(250);

        // hold key 0 for exactly 20 frames
        wait_phase(0);
        m  = cyc;
        s0 = strobes;
`ifdef KEYPAD_AUTOREPEAT_EN
        repeat (3) exp_q.push_back(4'd0);
`else
        exp_q.push_back(4'd0);
`endif
        keys[0] = 1'b1;
        step(800);
        keys = '0;
        step(250);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("key0_strobes", strobes - s0, 3);
        check("key0_last_strobe", last_strobe, m + 760);
`else
        check("key0_strobes", strobes - s0, 1);
        check("key0_last_strobe", last_strobe, m + 120);
`endif
        check("key0_released", int'(pressed), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
